// File: rtl/counter_pkg.sv
// ============================================================================
// counter_pkg: shared width default and count type for the counter blocks.
// Rev 1.0
// ============================================================================
`default_nettype none

package counter_pkg;

  localparam int COUNTER_WIDTH_DEFAULT = 8;

  typedef logic [COUNTER_WIDTH_DEFAULT-1:0] count_t;

endpackage

`default_nettype wire

// File: rtl/async_reset_counter.sv
// ============================================================================
// async_reset_counter: enable-gated wrapping up-counter with async clear.
// Rev 1.0
// ============================================================================
`default_nettype none

module async_reset_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] count;

  // Carry-out is dropped so the count wraps modulo 2^WIDTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (ena) begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign result = count;

`ifndef SYNTHESIS
  a_reset_clears : assert property (@(posedge clk) reset |-> (result == '0));

  a_increment : assert property (@(posedge clk) disable iff (reset)
    ena |=> (result == $past(result) + {{(WIDTH-1){1'b0}}, 1'b1}));

  a_hold : assert property (@(posedge clk) disable iff (reset)
    !ena |=> (result == $past(result)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_async_reset_counter.sv
// ============================================================================
// tb_async_reset_counter: directed checks of the 8-bit async-clear counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_async_reset_counter;
  import counter_pkg::*;

  logic   clk;
  logic   reset;
  logic   ena;
  count_t result;

  int errors = 0;
  int checks = 0;

  async_reset_counter #(.WIDTH(COUNTER_WIDTH_DEFAULT)) dut (
    .clk    (clk),
    .reset  (reset),
    .ena    (ena),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input count_t expected);
    checks++;
    assert (result === expected) else begin
      errors++;
      $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, result, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    count_t model;

    // Power-up: reset held with ena high keeps the count at zero.
    reset = 1'b1;
    ena   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("powerup", 8'h00);
    end

    // Release between edges and count ten steps.
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("count", 8'(i));
    end

    // Hold with ena low, then one more enabled edge.
    @(negedge clk);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold", 8'h0A);
    end
    @(negedge clk);
    ena = 1'b1;
    step();
    check("resume", 8'h0B);

    // Run up to the top value, then wrap.
    model = 8'h0B;
    while (model != 8'hFF) begin
      step();
      model = model + 8'h01;
    end
    check("reach_ff", 8'hFF);
    step();
    check("wrap_00", 8'h00);
    step();
    check("wrap_01", 8'h01);

    // Count to 0x37 and clear asynchronously between edges.
    model = 8'h01;
    while (model != 8'h37) begin
      step();
      model = model + 8'h01;
    end
    check("reach_37", 8'h37);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_clear", 8'h00);
    step();
    check("clear_hold_a", 8'h00);
    step();
    check("clear_hold_b", 8'h00);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("after_clear", 8'h01);
    step();
    check("after_clear2", 8'h02);

    // Reset high together with ena across an edge: no increment.
    @(negedge clk);
    #4;
    reset = 1'b1;
    ena   = 1'b1;
    step();
    check("reset_ena_edge", 8'h00);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("post_simul", 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
